thrd_pc_file: RTL and testbench

// - Per-thread program-counter table and fetch-request issuer in IF, directly downstream of thread_ctrl.
// - Each cycle it takes the thread selected by thread_ctrl (cur_thrd) and reads that thread's PC.
// - If the thread is valid and running, it issues one fetch request to instruction memory and advances that PC.
// - Applies branch redirects from EX and initial PCs for newly created threads.

---
 rtl/thread_pkg.sv | 16 +
 rtl/thrd_pc_file.sv | 153 +++++++++++++++
 tb/tb_thrd_pc_file.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thread_pkg.sv
// Shared types and constants for the per-thread PC file in the IF stage.
package thread_pkg;

  localparam int NUM_THRD = 8;
  localparam int THRD_W   = $clog2(NUM_THRD);
  localparam int PC_W     = 32;
  localparam int PERF_W   = 16;

  localparam logic [PC_W-1:0] RST_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef logic [THRD_W-1:0] thrd_id_t;
  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [PERF_W-1:0] perf_cnt_t;

endpackage : thread_pkg

// File: rtl/thrd_pc_file.sv
// Per-thread program-counter table and fetch-request issuer.
// Each cycle the thread picked by thread_ctrl is looked up. If that thread is
// valid and running, a fetch request is registered toward imem and the PC is
// advanced. EX redirects and thread creation overwrite PCs. A held request is
// dropped when its thread is redirected, killed or put to sleep.
// Optional feature: define THRD_PC_PERF_EN to add per-thread saturating
// counters of accepted fetches, read through perf_sel/perf_cnt.
module thrd_pc_file
  import thread_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  thrd_id_t            cur_thrd,
  input  logic [NUM_THRD-1:0] valid_thrd,
  input  logic [NUM_THRD-1:0] run_thrd,
  input  logic                stall,
  input  logic                new_vld,
  input  thrd_id_t            new_thrd,
  input  pc_t                 new_pc,
  input  logic                redir_vld,
  input  thrd_id_t            redir_thrd,
  input  pc_t                 redir_pc,
  output logic                fetch_vld,
  output pc_t                 fetch_pc,
  output thrd_id_t            fetch_thrd,
  input  logic                fetch_rdy,
  output logic                pc_err
`ifdef THRD_PC_PERF_EN
  ,
  input  thrd_id_t            perf_sel,
  output perf_cnt_t           perf_cnt
`endif
);

  pc_t      pc_q [NUM_THRD];
  pc_t      pc_d [NUM_THRD];
  logic     fetch_vld_q, fetch_vld_d;
  pc_t      fetch_pc_q, fetch_pc_d;
  thrd_id_t fetch_thrd_q, fetch_thrd_d;
  logic     pc_err_q, pc_err_d;

  logic free;
  logic accept;
  logic held;
  logic issue;
  logic squash;
  logic redir_ok;

  // Handshake qualifiers and the issue / squash decisions for this cycle.
  always_comb begin
    free     = !fetch_vld_q || fetch_rdy;
    accept   = fetch_vld_q && fetch_rdy;
    held     = fetch_vld_q && !fetch_rdy;
    // A redirect of the selected thread blocks its issue: the PC is about to change.
    issue    = !stall && free && valid_thrd[cur_thrd] && run_thrd[cur_thrd]
               && !(redir_vld && (redir_thrd == cur_thrd));
    squash   = held && ((redir_vld && (redir_thrd == fetch_thrd_q))
                        || !valid_thrd[fetch_thrd_q]
                        || !run_thrd[fetch_thrd_q]);
    // Redirects to dead threads are dropped (and flagged below).
    redir_ok = redir_vld && valid_thrd[redir_thrd];
  end

  // Next state of the registered fetch request: issue, drain, squash or hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    fetch_vld_d  = fetch_vld_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_thrd_d = fetch_thrd_q;
    if (issue) begin
      fetch_vld_d  = 1'b1;
      fetch_pc_d   = pc_q[cur_thrd];
      fetch_thrd_d = cur_thrd;
    end else if (free || squash) begin
      fetch_vld_d  = 1'b0;
    end
  end

  // Per-entry PC write mux, priority redirect > create > issue increment.
  always_comb begin
    for (int i = 0; i < NUM_THRD; i++) begin
      pc_d[i] = pc_q[i];
      if (redir_ok && (redir_thrd == thrd_id_t'(i))) begin
        pc_d[i] = redir_pc;
      end else if (new_vld && (new_thrd == thrd_id_t'(i))) begin
        pc_d[i] = new_pc;
      end else if (issue && (cur_thrd == thrd_id_t'(i))) begin
        pc_d[i] = pc_q[i] + PC_INC;
      end
    end
  end

  // Sticky protocol error from thread_ctrl / EX misuse.
  always_comb begin
    pc_err_d = pc_err_q
             | (new_vld && valid_thrd[new_thrd])
             | (new_vld && redir_vld && (new_thrd == redir_thrd))
             | (redir_vld && !valid_thrd[redir_thrd]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      // NOTE: the PC table is a flop array, not a RAM, so every entry can and must be reset.
      for (int i = 0; i < NUM_THRD; i++) pc_q[i] <= RST_PC;
      fetch_vld_q  <= 1'b0;
      fetch_pc_q   <= '0;
      fetch_thrd_q <= '0;
      pc_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THRD; i++) pc_q[i] <= pc_d[i];
      fetch_vld_q  <= fetch_vld_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_thrd_q <= fetch_thrd_d;
      pc_err_q     <= pc_err_d;
    end
  end

  assign fetch_vld  = fetch_vld_q;
  assign fetch_pc   = fetch_pc_q;
  assign fetch_thrd = fetch_thrd_q;
  assign pc_err     = pc_err_q;

`ifdef THRD_PC_PERF_EN
  perf_cnt_t cnt_q [NUM_THRD];
  perf_cnt_t cnt_d [NUM_THRD];

  // Saturating accepted-fetch counters; a thread create clears its counter.
  always_comb begin
    for (int i = 0; i < NUM_THRD; i++) begin
      cnt_d[i] = cnt_q[i];
      if (new_vld && (new_thrd == thrd_id_t'(i))) begin
        cnt_d[i] = '0;
      end else if (accept && (fetch_thrd_q == thrd_id_t'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + perf_cnt_t'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THRD; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_THRD; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign perf_cnt = cnt_q[perf_sel];
`endif

endmodule : thrd_pc_file

// File: tb/tb_thrd_pc_file.sv
// Self-checking bench for thrd_pc_file: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a behavioural model.
module tb_thrd_pc_file;
  import thread_pkg::*;

  typedef struct packed {
    pc_t      pc;
    thrd_id_t thrd;
  } req_t;

  logic                clk = 1'b0;
  logic                rst;
  thrd_id_t            cur_thrd;
  logic [NUM_THRD-1:0] valid_thrd;
  logic [NUM_THRD-1:0] run_thrd;
  logic                stall;
  logic                new_vld;
  thrd_id_t            new_thrd;
  pc_t                 new_pc;
  logic                redir_vld;
  thrd_id_t            redir_thrd;
  pc_t                 redir_pc;
  logic                fetch_vld;
  pc_t                 fetch_pc;
  thrd_id_t            fetch_thrd;
  logic                fetch_rdy;
  logic                pc_err;
`ifdef THRD_PC_PERF_EN
  thrd_id_t            perf_sel;
  perf_cnt_t           perf_cnt;
`endif

  always #5 clk = ~clk;

  thrd_pc_file dut (
    .clk        (clk),
    .rst        (rst),
    .cur_thrd   (cur_thrd),
    .valid_thrd (valid_thrd),
    .run_thrd   (run_thrd),
    .stall      (stall),
    .new_vld    (new_vld),
    .new_thrd   (new_thrd),
    .new_pc     (new_pc),
    .redir_vld  (redir_vld),
    .redir_thrd (redir_thrd),
    .redir_pc   (redir_pc),
    .fetch_vld  (fetch_vld),
    .fetch_pc   (fetch_pc),
    .fetch_thrd (fetch_thrd),
    .fetch_rdy  (fetch_rdy),
    .pc_err     (pc_err)
`ifdef THRD_PC_PERF_EN
    ,
    .perf_sel   (perf_sel),
    .perf_cnt   (perf_cnt)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: thread PCs as a plain array, one outstanding request.
  pc_t  m_pc [NUM_THRD];
  bit   m_vld;
  bit   m_err;
  int   m_cnt [NUM_THRD];
  req_t sb_q [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit free, iss, held, sq;
    thrd_id_t ht;
    if (rst) begin
      for (int i = 0; i < NUM_THRD; i++) begin
        m_pc[i]  = RST_PC;
        m_cnt[i] = 0;
      end
      m_vld = 1'b0;
      m_err = 1'b0;
      sb_q.delete();
      return;
    end
    free = !m_vld || fetch_rdy;
    held = m_vld && !fetch_rdy;
    iss  = !stall && free && valid_thrd[cur_thrd] && run_thrd[cur_thrd]
           && !(redir_vld && redir_thrd == cur_thrd);
    ht   = (sb_q.size() > 0) ? sb_q[$].thrd : '0;
    sq   = held && ((redir_vld && redir_thrd == ht) || !valid_thrd[ht] || !run_thrd[ht]);
    if (m_vld && fetch_rdy && m_cnt[ht] < 65535) m_cnt[ht]++;
    if (iss) begin
      sb_q.push_back('{pc: m_pc[cur_thrd], thrd: cur_thrd});
      m_vld = 1'b1;
    end else if (free) begin
      m_vld = 1'b0;
    end else if (sq) begin
      m_vld = 1'b0;
      void'(sb_q.pop_back());
    end
    if (new_vld && valid_thrd[new_thrd]) m_err = 1'b1;
    if (new_vld && redir_vld && new_thrd == redir_thrd) m_err = 1'b1;
    if (redir_vld && !valid_thrd[redir_thrd]) m_err = 1'b1;
    // Apply lowest priority first so higher-priority writes win.
    if (iss) m_pc[cur_thrd] = m_pc[cur_thrd] + 32'd4;
    if (new_vld) begin
      m_pc[new_thrd]  = new_pc;
      m_cnt[new_thrd] = 0;
    end
    if (redir_vld && valid_thrd[redir_thrd]) m_pc[redir_thrd] = redir_pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; new_vld = 1'b0; redir_vld = 1'b0;
    new_thrd = '0; new_pc = '0; redir_thrd = '0; redir_pc = '0;
  endtask

  task automatic drain();
    idle();
    valid_thrd = '0;
    run_thrd   = '0;
    fetch_rdy  = 1'b1;
    tick();
  endtask

  function automatic pc_t rand_pc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic rand_cycle(bit allow_err);
    idle();
    cur_thrd  = thrd_id_t'($urandom_range(0, NUM_THRD - 1));
    if ($urandom_range(0, 9) == 0) valid_thrd = NUM_THRD'($urandom);
    if ($urandom_range(0, 4) == 0) run_thrd = NUM_THRD'($urandom | $urandom);
    stall     = ($urandom_range(0, 4) == 0);
    fetch_rdy = ($urandom_range(0, 9) < 7);
    if ($urandom_range(0, 7) == 0) begin
      new_thrd = thrd_id_t'($urandom_range(0, NUM_THRD - 1));
      new_pc   = rand_pc();
      new_vld  = allow_err || !valid_thrd[new_thrd];
    end
    if ($urandom_range(0, 7) == 0) begin
      redir_thrd = thrd_id_t'($urandom_range(0, NUM_THRD - 1));
      redir_pc   = rand_pc();
      redir_vld  = allow_err || valid_thrd[redir_thrd];
    end
    if (new_vld && redir_vld && new_thrd == redir_thrd && !valid_thrd[redir_thrd])
      redir_vld = 1'b0;
`ifdef THRD_PC_PERF_EN
    perf_sel = thrd_id_t'($urandom_range(0, NUM_THRD - 1));
`endif
  endtask

  // Monitor: compares DUT outputs with the model and retires accepted requests.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("fetch_vld", 32'(fetch_vld), 32'(m_vld));
        check("pc_err", 32'(pc_err), 32'(m_err));
        if (m_vld) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got request pc 0x%0h with no expected entry", fetch_pc);
          end else begin
            check("sb_fetch_pc", fetch_pc, sb_q[0].pc);
            check("sb_fetch_thrd", 32'(fetch_thrd), 32'(sb_q[0].thrd));
            if (fetch_rdy) void'(sb_q.pop_front());
          end
        end
`ifdef THRD_PC_PERF_EN
        check("perf_cnt", 32'(perf_cnt), 32'(m_cnt[perf_sel]));
`endif
      end
    end
  end

  initial begin
    idle();
    cur_thrd   = '0;
    valid_thrd = '0;
    run_thrd   = '0;
    fetch_rdy  = 1'b0;
`ifdef THRD_PC_PERF_EN
    perf_sel   = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_fetch_vld", 32'(fetch_vld), 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_pc_err", 32'(pc_err), 32'd0);

    // Thread 0 fetches sequentially from the reset PC.
    valid_thrd = 8'b0000_0001; run_thrd = 8'b0000_0001; cur_thrd = 3'd0; fetch_rdy = 1'b1;
    tick(); check("seq_pc0", fetch_pc, 32'h0); check("seq_thrd", 32'(fetch_thrd), 32'd0);
    tick(); check("seq_pc1", fetch_pc, 32'h4);
    tick(); check("seq_pc2", fetch_pc, 32'h8);
    drain();

    // Held request of thread 2 is squashed by a redirect; next fetch uses the target.
    new_vld = 1'b1; new_thrd = 3'd2; new_pc = 32'h10;
    tick();
    idle();
    valid_thrd = 8'b0000_0100; run_thrd = 8'b0000_0100; cur_thrd = 3'd2; fetch_rdy = 1'b0;
    tick(); check("held_pc", fetch_pc, 32'h10); check("held_thrd", 32'(fetch_thrd), 32'd2);
    redir_vld = 1'b1; redir_thrd = 3'd2; redir_pc = 32'h100; stall = 1'b1;
    tick(); check("squash_vld", 32'(fetch_vld), 32'd0);
    idle();
    fetch_rdy = 1'b1;
    tick(); check("redir_pc", fetch_pc, 32'h100);
    drain();

    // Thread 5 created at 0x2000.
    new_vld = 1'b1; new_thrd = 3'd5; new_pc = 32'h2000;
    tick();
    idle();
    valid_thrd = 8'b0010_0000; run_thrd = 8'b0010_0000; cur_thrd = 3'd5;
    tick(); check("create_pc0", fetch_pc, 32'h2000);
    tick(); check("create_pc1", fetch_pc, 32'h2004);
    drain();

    // Thread 1 PC wraps from the top of the address space.
    valid_thrd = 8'b0000_0010; run_thrd = 8'b0000_0010; cur_thrd = 3'd1;
    redir_vld = 1'b1; redir_thrd = 3'd1; redir_pc = 32'hFFFF_FFFC;
    tick(); check("redir_blocks_issue", 32'(fetch_vld), 32'd0);
    redir_vld = 1'b0;
    tick(); check("wrap_pc_top", fetch_pc, 32'hFFFF_FFFC);
    tick(); check("wrap_pc_zero", fetch_pc, 32'h0);
    drain();

    // Stall does not disturb a held request; it is accepted exactly once.
    valid_thrd = 8'b0000_0001; run_thrd = 8'b0000_0001; cur_thrd = 3'd0; fetch_rdy = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold_vld", 32'(fetch_vld), 32'd1);
      check("stall_hold_pc", fetch_pc, 32'hC);
    end
    fetch_rdy = 1'b1;
    tick(); check("stall_accept_once", 32'(fetch_vld), 32'd0);
    drain();

    // Creating an already valid thread flags pc_err but still loads the PC.
    valid_thrd = 8'b0000_1000; run_thrd = 8'b0000_0000; cur_thrd = 3'd3;
    new_vld = 1'b1; new_thrd = 3'd3; new_pc = 32'h3000;
    tick(); check("err_set", 32'(pc_err), 32'd1);
    idle();
    run_thrd = 8'b0000_1000;
    tick(); check("err_create_pc", fetch_pc, 32'h3000);
    drain();
    for (int i = 0; i < 3; i++) tick();
    check("err_sticky", 32'(pc_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 32'(pc_err), 32'd0);

    // Randomized traffic: protocol-clean first, then with misuse allowed.
    valid_thrd = NUM_THRD'($urandom);
    run_thrd   = NUM_THRD'($urandom);
    for (int i = 0; i < 600; i++) begin
      rand_cycle(1'b0);
      tick();
    end
    check("clean_no_err", 32'(pc_err), 32'd0);
    for (int i = 0; i < 400; i++) begin
      rand_cycle(1'b1);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_rst_vld", 32'(fetch_vld), 32'd0);
    check("final_rst_err", 32'(pc_err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_thrd_pc_file
